ps2_frame_rx: RTL and testbench
===============================

// Module: ps2_frame_rx
// PURPOSE
//   Receives raw PS/2 frames from the keyboard (start, 8 data LSB-first, odd parity, stop) on vga_clk.
//   Folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags on one completed scan code.
//   Sits directly upstream of the arrow/fire key decoder: delivers one validated code per key event,
//   so the decoder never sees partial frames, prefix bytes or corrupted bytes.
// PARAMETERS
//   FILTER_LEN   4      consecutive equal samples required before a filtered line changes (2..15)
//   TIMEOUT_CYC  50000  vga_clk cycles with no PS/2 clock fall before a started frame is aborted (2 ms @25 MHz)
// PORTS
//   vga_clk     in   1  system clock
//   rst         in   1  asynchronous reset, active-high
//   ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//   ps2_dat     in   1  raw PS/2 data pin (asynchronous)
//   code        out  8  received scan code; held until the next code_valid
//   code_ext    out  1  code was preceded by 0xE0
//   code_brk    out  1  code was preceded by 0xF0 (key release)
//   code_valid  out  1  one-cycle strobe: code/code_ext/code_brk are new
//   frame_err   out  1  one-cycle strobe: parity, stop or timeout error
//   err_cnt     out  8  saturating error count (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst=1): all outputs 0; state IDLE; filtered clk/dat = 1; prefix flags 0; counters 0.
//   - Input path: 2-FF synchronizer per line, then filter. The filtered value takes the input value only
//     after FILTER_LEN consecutive equal synchronized samples. Sample event = filtered clk 1->0.
//   - FSM, advancing on sample events only:
//     IDLE:   dat=0 -> DATA, bit_cnt=0, parity accumulator=0. dat=1 -> stay IDLE, no error (glitch).
//     DATA:   shift dat into shreg[bit_cnt] (LSB first). After bit 7 -> PARITY.
//     PARITY: capture bit. Error if the 9 bits (data+parity) contain an even number of ones -> STOP.
//     STOP:   dat=1 and parity ok -> byte accepted. Else frame_err. Always -> IDLE.
//   - Accepted byte 0xE0: set ext_pend, no strobe. 0xF0: set brk_pend, no strobe.
//     Any other byte (incl. 0xE1): code<=byte, code_ext<=ext_pend, code_brk<=brk_pend, code_valid=1,
//     then clear both pend flags.
//   - Latency: the stop-bit sample event is seen in cycle N; code_valid or frame_err is high in N+1
//     for exactly one cycle. code_valid and frame_err are never high in the same cycle.
//   - Timeout: the counter resets on every sample event and counts only when not IDLE. When it reaches
//     TIMEOUT_CYC: -> IDLE, frame_err pulse, partial byte discarded. If a sample event occurs in the same
//     cycle, the event wins and no timeout fires. Counter width $clog2(TIMEOUT_CYC+1).
//   - Any frame_err clears ext_pend and brk_pend. A sequence of E0,F0 sets both flags.
//   - Reset asserted mid-frame: frame abandoned, no strobe. After release, reception resumes at the next start bit.
// CONFIGURATION
//   PS2_ERR_CNT_EN defined: err_cnt increments on every frame_err pulse and saturates at 8'hFF;
//   cleared only by rst. Not defined: err_cnt tied to 8'h00 and no counter logic is built.
// STRUCTURE
//   Package ps2_pkg: rx state enum {IDLE, DATA, PARITY, STOP}; constants PS2_PFX_EXT=8'hE0,
//   PS2_PFX_BRK=8'hF0 and arrow/F/B scan codes (75,6B,72,74,2B,32). The decoder imports the same package.
//   Sub-module ps2_line_filter (synchronizer + FILTER_LEN filter, parameterised) is instantiated twice:
//   once for ps2_clk, once for ps2_dat.
// TESTING
//   Bench model: PS/2 device with bit period 2000 vga_clk; data changes mid-high; check one cycle after each stop fall.
//   1 Frame 0x1C, parity 0 -> code=1C, ext=0, brk=0, one code_valid, frame_err=0.
//   2 Bytes E0,F0,75 -> exactly one code_valid: code=75, ext=1, brk=1; next byte 6B gives ext=0, brk=0.
//   3 Frame 0x2B with wrong parity -> frame_err pulse, no code_valid; err_cnt=1 with PS2_ERR_CNT_EN, else 0.
//   4 Stop 6 bits into a frame for 60000 cycles -> frame_err at cycle TIMEOUT_CYC; next good frame 0x32 is received.
//   5 Clock glitch of FILTER_LEN-1 cycles low on idle line, and E0 then bad-stop frame -> no strobe for the glitch;
//     frame_err for the bad frame; ext_pend cleared, so next 74 gives ext=0.
//   6 Assert rst during bit 4 -> all outputs 0 immediately; post-release frame 0x72 gives code=72.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, prefix bytes and the scan codes
// used by the arrow/fire key decoder.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;

  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_F     = 8'h2B;
  localparam logic [7:0] PS2_KEY_B     = 8'h32;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output follows the
// input only after FILTER_LEN consecutive synchronized samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] run_cnt;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      run_cnt <= '0;
      dout    <= 1'b1;
    end else begin
      // synchronizer p0 -> p1, filter on p1
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      if (sync_p1 == dout) begin
        run_cnt <= '0;
      end else if (run_cnt == 4'(FILTER_LEN - 1)) begin
        dout    <= sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: filters the raw lines, deframes 11-bit frames and folds E0/F0
// prefixes into flags on the following code. Define PS2_ERR_CNT_EN to build err_cnt.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic            clk_f, dat_f, clk_f_p2, sample_evt;
  rx_state_t       state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            par_acc, par_acc_n, par_err, par_err_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            ext_pend, ext_pend_n, brk_pend, brk_pend_n;
  logic [7:0]      code_n;
  logic            code_ext_n, code_brk_n, code_valid_n, frame_err_n, byte_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .vga_clk(vga_clk), .rst(rst), .din(ps2_clk), .dout(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .vga_clk(vga_clk), .rst(rst), .din(ps2_dat), .dout(dat_f)
  );

  assign sample_evt = clk_f_p2 & ~clk_f;

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_acc_n    = par_acc;
    par_err_n    = par_err;
    to_cnt_n     = to_cnt;
    ext_pend_n   = ext_pend;
    brk_pend_n   = brk_pend;
    code_n       = code;
    code_ext_n   = code_ext;
    code_brk_n   = code_brk;
    code_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    byte_ok      = 1'b0;

    if (sample_evt) begin
      to_cnt_n = '0;
      case (state)
        IDLE: begin
          if (!dat_f) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            par_acc_n = 1'b0;
          end
        end
        DATA: begin
          shreg_n[bit_cnt] = dat_f;
          par_acc_n        = par_acc ^ dat_f;
          if (bit_cnt == 3'd7) state_n = PARITY;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
        PARITY: begin
          // odd parity: data ones plus parity bit must be odd
          par_err_n = ~(par_acc ^ dat_f);
          state_n   = STOP;
        end
        default: begin
          state_n = IDLE;
          if (dat_f && !par_err) byte_ok     = 1'b1;
          else                   frame_err_n = 1'b1;
        end
      endcase
    end else if (state != IDLE) begin
      if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
        state_n     = IDLE;
        frame_err_n = 1'b1;
        to_cnt_n    = '0;
      end else begin
        to_cnt_n = to_cnt + TO_W'(1);
      end
    end

    if (byte_ok) begin
      if (shreg == PS2_PFX_EXT) begin
        ext_pend_n = 1'b1;
      end else if (shreg == PS2_PFX_BRK) begin
        brk_pend_n = 1'b1;
      end else begin
        code_n       = shreg;
        code_ext_n   = ext_pend;
        code_brk_n   = brk_pend;
        code_valid_n = 1'b1;
        ext_pend_n   = 1'b0;
        brk_pend_n   = 1'b0;
      end
    end

    // a corrupted frame may have swallowed the byte the prefixes belonged to
    if (frame_err_n) begin
      ext_pend_n = 1'b0;
      brk_pend_n = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      clk_f_p2   <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_err    <= 1'b0;
      to_cnt     <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_brk   <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_f_p2   <= clk_f;
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_acc    <= par_acc_n;
      par_err    <= par_err_n;
      to_cnt     <= to_cnt_n;
      ext_pend   <= ext_pend_n;
      brk_pend   <= brk_pend_n;
      code       <= code_n;
      code_ext   <= code_ext_n;
      code_brk   <= code_brk_n;
      code_valid <= code_valid_n;
      frame_err  <= frame_err_n;
    end
  end

`ifdef PS2_ERR_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] err_cnt_q;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)            err_cnt_q <= '0;
    else if (frame_err) err_cnt_q <= sat_inc8(err_cnt_q);
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: a PS/2 device model drives frames, a negedge monitor
// counts strobes and every comparison goes through chk().
module tb_ps2_frame_rx;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 100;
`ifdef PS2_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       vga_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       code_ext, code_brk, code_valid, frame_err;
  logic [7:0] err_cnt;

  int cyc = 0, fall_cyc = 0, err_cyc = 0;
  int nvalid = 0, nerr = 0, both = 0;
  int checks = 0, errors = 0;
  int v0, e0, dly;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .vga_clk(vga_clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .code(code), .code_ext(code_ext), .code_brk(code_brk),
    .code_valid(code_valid), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  always @(negedge vga_clk) begin
    if (code_valid) nvalid <= nvalid + 1;
    if (frame_err) begin
      nerr    <= nerr + 1;
      err_cyc <= cyc;
    end
    if (code_valid && frame_err) both <= 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF / 2);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_good, input logic stop_bit,
                            input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (par_good ? ~^d : ^d), d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b1, 11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(5);
    chk("rst_code", code, 8'h00);
    chk("rst_valid", code_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_flags", {code_ext, code_brk}, 0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;
    wait_cyc(20);

    // plain make code
    v0 = nvalid; e0 = nerr;
    send(8'h1C);
    chk("t1_nvalid", nvalid, v0 + 1);
    chk("t1_code", code, 8'h1C);
    chk("t1_flags", {code_ext, code_brk}, 2'b00);
    chk("t1_nerr", nerr, e0);

    // extended break: E0 F0 75, then plain 6B
    v0 = nvalid;
    send(8'hE0);
    chk("t2_e0_nostrobe", nvalid, v0);
    send(8'hF0);
    chk("t2_f0_nostrobe", nvalid, v0);
    send(8'h75);
    chk("t2_nvalid", nvalid, v0 + 1);
    chk("t2_code", code, 8'h75);
    chk("t2_flags", {code_ext, code_brk}, 2'b11);
    send(8'h6B);
    chk("t2_code_6b", code, 8'h6B);
    chk("t2_flags_6b", {code_ext, code_brk}, 2'b00);

    // parity error
    v0 = nvalid; e0 = nerr;
    send_frame(8'h2B, 1'b0, 1'b1, 11);
    chk("t3_nerr", nerr, e0 + 1);
    chk("t3_nvalid", nvalid, v0);
    chk("t3_err_cnt", err_cnt, ERR_EN ? 8'd1 : 8'd0);

    // stalled frame times out
    v0 = nvalid; e0 = nerr;
    send_frame(8'h5A, 1'b1, 1'b1, 6);
    wait_cyc(TIMEOUT_CYC + 200);
    chk("t4_nerr", nerr, e0 + 1);
    chk("t4_nvalid", nvalid, v0);
    dly = err_cyc - fall_cyc;
    chk("t4_timeout_window", (dly >= TIMEOUT_CYC) && (dly <= TIMEOUT_CYC + 20), 1);
    send(8'h32);
    chk("t4_code", code, 8'h32);
    chk("t4_nvalid_after", nvalid, v0 + 1);

    // short clock glitch, then E0 followed by a bad stop bit
    v0 = nvalid; e0 = nerr;
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("t5_glitch_valid", nvalid, v0);
    chk("t5_glitch_err", nerr, e0);
    send(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    chk("t5_bad_stop_err", nerr, e0 + 1);
    chk("t5_bad_stop_valid", nvalid, v0);
    send(8'h74);
    chk("t5_code", code, 8'h74);
    chk("t5_flags", {code_ext, code_brk}, 2'b00);
    chk("t5_err_cnt", err_cnt, ERR_EN ? 8'd3 : 8'd0);

    // reset asserted during bit 4 of a frame
    v0 = nvalid;
    send_frame(8'h00, 1'b1, 1'b1, 4);
    ps2_dat = 1'b0;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    wait_cyc(HALF / 2);
    rst = 1'b1;
    #1;
    chk("t6_code", code, 8'h00);
    chk("t6_valid_err", {code_valid, frame_err}, 2'b00);
    chk("t6_flags", {code_ext, code_brk}, 2'b00);
    chk("t6_err_cnt", err_cnt, 8'h00);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(20);
    rst = 1'b0;
    wait_cyc(20);
    chk("t6_no_strobe", nvalid, v0);
    send(8'h72);
    chk("t6_code_72", code, 8'h72);
    chk("t6_nvalid", nvalid, v0 + 1);
    chk("t6_flags_72", {code_ext, code_brk}, 2'b00);

    chk("no_overlap", both, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
